// File: rtl/sb_at_rsp_tx_if.sv
// Response-request and symbol-stream signals between the decoder, sb_at_rsp_tx and the sideband serializer.
// slave = the transmitter; master = the request source plus serializer side.
interface sb_at_rsp_tx_if;
  logic        tdisconnect;
  logic        rsp_req;
  logic        rsp_write;
  logic [7:0]  rsp_address;
  logic [23:0] rsp_data;
  logic        sym_ready;
  logic [9:0]  sbtx;
  logic        sym_valid;
  logic        rsp_busy;
  logic        rsp_done;

  modport master (
    output tdisconnect, rsp_req, rsp_write, rsp_address, rsp_data, sym_ready,
    input  sbtx, sym_valid, rsp_busy, rsp_done
  );

  modport slave (
    input  tdisconnect, rsp_req, rsp_write, rsp_address, rsp_data, sym_ready,
    output sbtx, sym_valid, rsp_busy, rsp_done
  );
endinterface

// File: rtl/sb_at_rsp_tx.sv
// Sideband AT-response transmitter: frames one response as DLE STX ADDR CMD [D0..D2] CRC_L CRC_H DLE ETX.
// Defining SB_DLE_STUFF_EN inserts an extra DLE after any ADDR/CMD/DATA/CRC byte equal to DLE_SYMBOL.
module sb_at_rsp_tx #(
  parameter logic [7:0]  DLE_SYMBOL = 8'hFE,
  parameter logic [7:0]  STX_RSP    = 8'h04,
  parameter logic [7:0]  ETX_SYMBOL = 8'h40,
  parameter logic [15:0] CRC_POLY   = 16'h8005,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic          sb_clk,
  input  logic          rst,
  sb_at_rsp_tx_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SOF_DLE = 4'd1,
    ST_STX     = 4'd2,
    ST_ADDR    = 4'd3,
    ST_CMD     = 4'd4,
    ST_DATA    = 4'd5,
    ST_CRC     = 4'd6,
    ST_EOF_DLE = 4'd7,
    ST_ETX     = 4'd8
`ifdef SB_DLE_STUFF_EN
    , ST_STUFF = 4'd9
`endif
  } state_e;

  localparam logic [9:0] IDLE_LINE = 10'h3FF;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [23:0] data_q, data_d;
  logic [9:0]  sbtx_q, sbtx_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef SB_DLE_STUFF_EN
  state_e      ret_state_q, ret_state_d;
  logic [1:0]  ret_cnt_q, ret_cnt_d;
`endif
  state_e      nxt_state_s;
  logic [1:0]  nxt_cnt_s;
  logic        hs_s;
  logic [7:0]  cur_byte_s;
  logic [7:0]  sym_byte_s;

  // CRC-16, MSB of the byte first, no reflection
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ b[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input state_e st, input logic [1:0] cnt,
                                            input logic [7:0] addr, input logic wr,
                                            input logic [23:0] data, input logic [15:0] crc);
    logic [7:0] b;
    case (st)
      ST_SOF_DLE: b = DLE_SYMBOL;
      ST_STX:     b = STX_RSP;
      ST_ADDR:    b = addr;
      ST_CMD:     b = wr ? {1'b1, 7'd0} : {1'b0, 7'd3};
      ST_DATA: begin
        case (cnt)
          2'd0:    b = data[7:0];
          2'd1:    b = data[15:8];
          default: b = data[23:16];
        endcase
      end
      ST_CRC:     b = (cnt == 2'd0) ? crc[7:0] : crc[15:8];
      ST_EOF_DLE: b = DLE_SYMBOL;
      ST_ETX:     b = ETX_SYMBOL;
`ifdef SB_DLE_STUFF_EN
      ST_STUFF:   b = DLE_SYMBOL;
`endif
      default:    b = 8'hFF;
    endcase
    return b;
  endfunction

  // Next-state, request latch and running CRC; the byte being handshaken is the registered symbol
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    addr_d      = addr_q;
    write_d     = write_q;
    data_d      = data_q;
    done_d      = 1'b0;
    nxt_state_s = state_q;
    nxt_cnt_s   = cnt_q;
`ifdef SB_DLE_STUFF_EN
    ret_state_d = ret_state_q;
    ret_cnt_d   = ret_cnt_q;
`endif
    hs_s       = valid_q & bus.sym_ready;
    cur_byte_s = sbtx_q[8:1];

    if (bus.tdisconnect) begin
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else if (state_q == ST_IDLE) begin
      if (bus.rsp_req) begin
        addr_d  = bus.rsp_address;
        write_d = bus.rsp_write;
        data_d  = bus.rsp_data;
        crc_d   = CRC_INIT;
        state_d = ST_SOF_DLE;
        cnt_d   = 2'd0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (hs_s) begin
      nxt_cnt_s = 2'd0;
      case (state_q)
        ST_SOF_DLE: nxt_state_s = ST_STX;
        ST_STX: begin
          crc_d       = crc16_byte(crc_q, cur_byte_s);
          nxt_state_s = ST_ADDR;
        end
        ST_ADDR: begin
          crc_d       = crc16_byte(crc_q, cur_byte_s);
          nxt_state_s = ST_CMD;
        end
        ST_CMD: begin
          crc_d       = crc16_byte(crc_q, cur_byte_s);
          nxt_state_s = write_q ? ST_CRC : ST_DATA;
        end
        ST_DATA: begin
          crc_d = crc16_byte(crc_q, cur_byte_s);
          if (cnt_q == 2'd2) begin
            nxt_state_s = ST_CRC;
          end else begin
            nxt_state_s = ST_DATA;
            nxt_cnt_s   = cnt_q + 2'd1;
          end
        end
        ST_CRC: begin
          if (cnt_q == 2'd1) begin
            nxt_state_s = ST_EOF_DLE;
          end else begin
            nxt_state_s = ST_CRC;
            nxt_cnt_s   = cnt_q + 2'd1;
          end
        end
        ST_EOF_DLE: nxt_state_s = ST_ETX;
        ST_ETX: begin
          nxt_state_s = ST_IDLE;
          done_d      = 1'b1;
        end
`ifdef SB_DLE_STUFF_EN
        ST_STUFF: begin
          nxt_state_s = ret_state_q;
          nxt_cnt_s   = ret_cnt_q;
        end
`endif
        default: nxt_state_s = ST_IDLE;
      endcase

`ifdef SB_DLE_STUFF_EN
      // The stuffed DLE remembers where the frame resumes, including a mid-field counter
      if ((state_q == ST_ADDR || state_q == ST_CMD || state_q == ST_DATA || state_q == ST_CRC)
          && cur_byte_s == DLE_SYMBOL) begin
        state_d     = ST_STUFF;
        cnt_d       = 2'd0;
        ret_state_d = nxt_state_s;
        ret_cnt_d   = nxt_cnt_s;
      end else begin
        state_d = nxt_state_s;
        cnt_d   = nxt_cnt_s;
      end
`else
      state_d = nxt_state_s;
      cnt_d   = nxt_cnt_s;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // Symbol for the next cycle, encoded from the next state so every output leaves a flop
  always_comb begin
    sym_byte_s = frame_byte(state_d, cnt_d, addr_d, write_d, data_d, crc_d);
    busy_d     = (state_d != ST_IDLE);
    valid_d    = busy_d;
    if (busy_d) begin
      sbtx_d = {1'b1, sym_byte_s, 1'b0};
    end else begin
      sbtx_d = IDLE_LINE;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge sb_clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      crc_q       <= CRC_INIT;
      addr_q      <= 8'd0;
      write_q     <= 1'b0;
      data_q      <= 24'd0;
      sbtx_q      <= IDLE_LINE;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SB_DLE_STUFF_EN
      ret_state_q <= ST_IDLE;
      ret_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      data_q      <= data_d;
      sbtx_q      <= sbtx_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SB_DLE_STUFF_EN
      ret_state_q <= ret_state_d;
      ret_cnt_q   <= ret_cnt_d;
`endif
    end
  end

  assign bus.sbtx      = sbtx_q;
  assign bus.sym_valid = valid_q;
  assign bus.rsp_busy  = busy_q;
  assign bus.rsp_done  = done_q;

endmodule

// File: tb/tb_sb_at_rsp_tx.sv
// Bench for sb_at_rsp_tx: frame-level queue model checked every cycle, plus directed literal checks.
module tb_sb_at_rsp_tx;
  typedef logic [7:0] bq_t [$];

  logic sb_clk = 1'b0;
  logic rst    = 1'b0;
  sb_at_rsp_tx_if bus();

  sb_at_rsp_tx dut (.sb_clk(sb_clk), .rst(rst), .bus(bus));

  always #5 sb_clk = ~sb_clk;

  int   checks = 0;
  int   errors = 0;
  bq_t  exp_q;
  bq_t  cap_q;
  bq_t  body;
  bq_t  model_frame;
  bit   active = 1'b0;
  bit   done_next = 1'b0;
  bit   model_ok = 1'b0;
  int   vcount = 0;
  int   done_cnt = 0;
  int   rdy_mode = 0;
  int   d0;
  logic [9:0]  e_sbtx;
  logic [15:0] crc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain CRC-16 over the whole byte stream (poly 8005, seed FFFF, MSB first, no final XOR)
  function automatic logic [15:0] crc_model(input bq_t b);
    logic [15:0] r;
    logic        top;
    r = 16'hFFFF;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        top = r[15] ^ b[k][i];
        r   = {r[14:0], 1'b0};
        if (top) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  function automatic void frame_bytes(input logic w, input logic [7:0] a, input logic [23:0] d,
                                      output bq_t f);
    bq_t         bd;
    logic [15:0] c;
    bd = {8'h04, a, (w ? 8'h80 : 8'h03)};
    if (!w) begin
      bd.push_back(d[7:0]);
      bd.push_back(d[15:8]);
      bd.push_back(d[23:16]);
    end
    c = crc_model(bd);
    bd.push_back(c[7:0]);
    bd.push_back(c[15:8]);
    f = {8'hFE, 8'h04};
    for (int k = 1; k < bd.size(); k++) begin
      f.push_back(bd[k]);
`ifdef SB_DLE_STUFF_EN
      if (bd[k] == 8'hFE) f.push_back(8'hFE);
`endif
    end
    f.push_back(8'hFE);
    f.push_back(8'h40);
  endfunction

  // Compare against the model, then advance the model for the coming edge
  always @(negedge sb_clk) begin
    if (model_ok) begin
      if (active) e_sbtx = {1'b1, exp_q[0], 1'b0};
      else        e_sbtx = 10'h3FF;
      check("sym_valid", 32'(bus.sym_valid), 32'(active));
      check("sbtx",      32'(bus.sbtx),      32'(e_sbtx));
      check("rsp_busy",  32'(bus.rsp_busy),  32'(active));
      check("rsp_done",  32'(bus.rsp_done),  32'(done_next));
    end
    if (bus.sym_valid === 1'b1) vcount++;
    if (bus.rsp_done === 1'b1) done_cnt++;
    if (rst && !bus.tdisconnect && bus.sym_valid === 1'b1 && bus.sym_ready)
      cap_q.push_back(bus.sbtx[8:1]);

    done_next = 1'b0;
    if (!rst || bus.tdisconnect) begin
      active = 1'b0;
      exp_q.delete();
    end else if (!active) begin
      if (bus.rsp_req) begin
        frame_bytes(bus.rsp_write, bus.rsp_address, bus.rsp_data, exp_q);
        active = 1'b1;
      end
    end else if (bus.sym_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        active    = 1'b0;
        done_next = 1'b1;
      end
    end
    if (!rst) model_ok = 1'b1;
  end

  // Serializer side: ready always, alternating, or random
  initial begin
    bus.sym_ready = 1'b1;
    forever begin
      @(posedge sb_clk);
      #1;
      case (rdy_mode)
        0:       bus.sym_ready = 1'b1;
        1:       bus.sym_ready = ~bus.sym_ready;
        default: bus.sym_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [23:0] d);
    bus.rsp_write   = w;
    bus.rsp_address = a;
    bus.rsp_data    = d;
    bus.rsp_req     = 1'b1;
    tick();
    bus.rsp_req     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (bus.rsp_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.rsp_done), 32'd1);
  endtask

  initial begin
    bus.tdisconnect = 1'b0;
    bus.rsp_req     = 1'b0;
    bus.rsp_write   = 1'b0;
    bus.rsp_address = 8'h00;
    bus.rsp_data    = 24'h0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("reset_valid", 32'(bus.sym_valid), 32'd0);
    check("reset_sbtx",  32'(bus.sbtx),      32'h3FF);
    check("reset_busy",  32'(bus.rsp_busy),  32'd0);
    check("reset_done",  32'(bus.rsp_done),  32'd0);

    body = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_model_pin", 32'(crc_model(body)), 32'hAEE7);

    // 1: read frame with ready held high
    cap_q.delete();
    vcount = 0;
    send_req(1'b0, 8'h12, 24'hA1B2C3);
    check("t1_first_dle", 32'(bus.sbtx), 32'h3FC);
    wait_done(40, "t1_done");
    tick();
    body = {8'h04, 8'h12, 8'h03, 8'hC3, 8'hB2, 8'hA1};
    crc1 = crc_model(body);
    frame_bytes(1'b0, 8'h12, 24'hA1B2C3, model_frame);
    check("t1_len", 32'(cap_q.size()), 32'(model_frame.size()));
    check("t1_vcount", 32'(vcount), 32'(model_frame.size()));
    if (cap_q.size() >= 11) begin
      for (int k = 0; k < 7; k++) check("t1_byte", 32'(cap_q[k]), 32'(body.size() > 0 ? ((k == 0) ? 8'hFE : body[k-1]) : 8'h00));
      check("t1_crc_l", 32'(cap_q[7]), 32'(crc1[7:0]));
      check("t1_crc_h", 32'(cap_q[cap_q.size()-3]), 32'(crc1[15:8]));
      check("t1_eof",   32'(cap_q[cap_q.size()-2]), 32'hFE);
      check("t1_etx",   32'(cap_q[cap_q.size()-1]), 32'h40);
    end

    // 2: write frame, no data bytes
    cap_q.delete();
    vcount = 0;
    send_req(1'b1, 8'h08, 24'hFFFFFF);
    wait_done(40, "t2_done");
    tick();
    body = {8'h04, 8'h08, 8'h80};
    crc1 = crc_model(body);
    frame_bytes(1'b1, 8'h08, 24'h0, model_frame);
    check("t2_len", 32'(cap_q.size()), 32'(model_frame.size()));
    check("t2_vcount", 32'(vcount), 32'(model_frame.size()));
    if (cap_q.size() >= 8) begin
      check("t2_addr", 32'(cap_q[2]), 32'h08);
      check("t2_cmd",  32'(cap_q[3]), 32'h80);
      check("t2_crc_l", 32'(cap_q[4]), 32'(crc1[7:0]));
      check("t2_etx",  32'(cap_q[cap_q.size()-1]), 32'h40);
    end

    // 3: alternating ready
    rdy_mode = 1;
    cap_q.delete();
    send_req(1'b0, 8'h12, 24'hA1B2C3);
    wait_done(80, "t3_done");
    tick();
    frame_bytes(1'b0, 8'h12, 24'hA1B2C3, model_frame);
    check("t3_len", 32'(cap_q.size()), 32'(model_frame.size()));
    if (cap_q.size() >= 7) check("t3_d2", 32'(cap_q[6]), 32'hA1);
    rdy_mode = 0;

    // 4: disconnect while D1 is on the line
    begin
      int n;
      n = 0;
      send_req(1'b0, 8'h12, 24'hA1B2C3);
      while (!(bus.sym_valid === 1'b1 && bus.sbtx[8:1] == 8'hB2) && n < 20) begin
        tick();
        n++;
      end
      check("t4_reach_d1", 32'(bus.sbtx[8:1]), 32'hB2);
      d0 = done_cnt;
      bus.tdisconnect = 1'b1;
      bus.rsp_req     = 1'b1;
      tick();
      bus.tdisconnect = 1'b0;
      bus.rsp_req     = 1'b0;
      check("t4_valid", 32'(bus.sym_valid), 32'd0);
      check("t4_busy",  32'(bus.rsp_busy),  32'd0);
      repeat (4) tick();
      check("t4_no_done", 32'(done_cnt), 32'(d0));
      cap_q.delete();
      send_req(1'b1, 8'h44, 24'h0);
      check("t4_restart", 32'(bus.sbtx[8:1]), 32'hFE);
      wait_done(40, "t4_done");
      tick();
      if (cap_q.size() > 2) check("t4_addr", 32'(cap_q[2]), 32'h44);
    end

    // 5: request while busy ignored, request in the done cycle accepted
    cap_q.delete();
    d0 = done_cnt;
    send_req(1'b0, 8'h21, 24'h123456);
    repeat (3) tick();
    send_req(1'b1, 8'h55, 24'h0);
    wait_done(40, "t5_done1");
    send_req(1'b1, 8'h66, 24'h0);
    check("t5_second_dle", 32'(bus.sbtx), 32'h3FC);
    check("t5_second_busy", 32'(bus.rsp_busy), 32'd1);
    wait_done(40, "t5_done2");
    tick();
    check("t5_done_count", 32'(done_cnt - d0), 32'd2);
    check("t5_len", 32'(cap_q.size()), 32'd19);
    if (cap_q.size() >= 14) begin
      check("t5_addr1", 32'(cap_q[2]),  32'h21);
      check("t5_addr2", 32'(cap_q[13]), 32'h66);
    end

    // 6: data byte equal to DLE
    cap_q.delete();
    send_req(1'b0, 8'h3C, 24'h0000FE);
    wait_done(40, "t6_done");
    tick();
    frame_bytes(1'b0, 8'h3C, 24'h0000FE, model_frame);
    check("t6_len", 32'(cap_q.size()), 32'(model_frame.size()));
    if (cap_q.size() >= 7) begin
      check("t6_d0", 32'(cap_q[4]), 32'hFE);
`ifdef SB_DLE_STUFF_EN
      check("t6_stuff", 32'(cap_q[5]), 32'hFE);
`else
      check("t6_d1", 32'(cap_q[5]), 32'h00);
`endif
    end

    // Reset in the middle of a frame
    send_req(1'b0, 8'h77, 24'h111111);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_valid", 32'(bus.sym_valid), 32'd0);
    check("rst_mid_sbtx",  32'(bus.sbtx),      32'h3FF);
    tick();

    // Random traffic: requests, stalls and disconnects
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      bus.rsp_req     = ($urandom_range(0, 7) == 0);
      bus.rsp_write   = 1'($urandom_range(0, 1));
      bus.rsp_address = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      bus.rsp_data    = ($urandom_range(0, 3) == 0) ? {8'hFE, 8'($urandom), 8'hFE} : 24'($urandom);
      bus.tdisconnect = ($urandom_range(0, 99) == 0);
      tick();
    end
    bus.rsp_req     = 1'b0;
    bus.tdisconnect = 1'b0;
    rdy_mode = 0;
    begin
      int n;
      n = 0;
      while (bus.rsp_busy === 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("drain_idle", 32'(bus.rsp_busy), 32'd0);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
